// File: rtl/data_memory_pkg.sv
// data_memory_pkg: data segment base, arbiter state encoding and the address range check.
package data_memory_pkg;

    localparam logic [31:0] BASE_ADDR = 32'h1001_0000;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        ACCESS = 2'b01,
        RESP   = 2'b10
    } state_t;

    // 33-bit compare so the end of the segment cannot wrap past 2^32
    function automatic logic addr_err(input logic [31:0] addr, input logic [31:0] base,
                                      input int unsigned depth);
        logic [32:0] lim;
        lim = {1'b0, base} + 33'(depth) * 33'd4;
        return (addr[1:0] != 2'b00) || ({1'b0, addr} < {1'b0, base}) || ({1'b0, addr} >= lim);
    endfunction

endpackage

// File: rtl/rr_arbiter_2.sv
// rr_arbiter_2: combinational two-way round-robin picker; a tie goes to the requester not granted last.
module rr_arbiter_2 (
    input  logic [1:0] valid,
    input  logic       last_grant,
    output logic [1:0] grant
);

    always_comb begin
        grant[0] = valid[0] && (!valid[1] || last_grant);
        grant[1] = valid[1] && (!valid[0] || !last_grant);
    end

endmodule

// File: rtl/data_memory_arbiter.sv
// data_memory_arbiter: round-robin two-port front end for the single-port Data_Memory.
// One transaction per three cycles: accept, strobe memory, respond.
module data_memory_arbiter
    import data_memory_pkg::*;
#(
    parameter int          DATA_WIDTH   = 32,
    parameter int          MEMORY_DEPTH = 256,
    parameter logic [31:0] BASE_ADDR    = data_memory_pkg::BASE_ADDR
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [1:0]              req_valid_i,
    input  logic [1:0]              req_write_i,
    input  logic [2*DATA_WIDTH-1:0] req_addr_i,
    input  logic [2*DATA_WIDTH-1:0] req_wdata_i,
    output logic [1:0]              req_ready_o,
    output logic [1:0]              rsp_valid_o,
    output logic [DATA_WIDTH-1:0]   rsp_rdata_o,
    output logic                    rsp_err_o,
    output logic                    Mem_Write_o,
    output logic                    Mem_Read_o,
    output logic [DATA_WIDTH-1:0]   Address_o,
    output logic [DATA_WIDTH-1:0]   Write_Data_o,
    input  logic [DATA_WIDTH-1:0]   Read_Data_i
);

    state_t                state, state_n;
    logic                  last_grant, owner, wr, err, rsp_err;
    logic [1:0]            grant;
    logic [DATA_WIDTH-1:0] addr, wdata, rsp_rdata, sel_addr, sel_wdata;

    rr_arbiter_2 u_rr (
        .valid      (req_valid_i),
        .last_grant (last_grant),
        .grant      (grant)
    );

    assign sel_addr  = grant[1] ? req_addr_i[2*DATA_WIDTH-1:DATA_WIDTH]  : req_addr_i[DATA_WIDTH-1:0];
    assign sel_wdata = grant[1] ? req_wdata_i[2*DATA_WIDTH-1:DATA_WIDTH] : req_wdata_i[DATA_WIDTH-1:0];

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            owner      <= 1'b0;
            wr         <= 1'b0;
            err        <= 1'b0;
            addr       <= '0;
            wdata      <= '0;
            rsp_rdata  <= '0;
            rsp_err    <= 1'b0;
        end else begin
            state <= state_n;
            if (state == IDLE && |grant) begin
                last_grant <= grant[1];
                owner      <= grant[1];
                wr         <= req_write_i[grant[1]];
                addr       <= sel_addr;
                wdata      <= sel_wdata;
                err        <= addr_err(sel_addr, BASE_ADDR, MEMORY_DEPTH);
            end
            if (state == ACCESS) begin
                rsp_rdata <= (!wr && !err) ? Read_Data_i : '0;
                rsp_err   <= err;
            end
        end
    end

    // ready and response pulses are masked while reset is held so nothing leaks out mid-reset
    always_comb begin
        state_n      = (state == IDLE && |req_valid_i) ? ACCESS : (state == ACCESS) ? RESP : IDLE;
        req_ready_o  = (state == IDLE && reset) ? grant : 2'b00;
        rsp_valid_o  = (state == RESP && reset) ? (owner ? 2'b10 : 2'b01) : 2'b00;
        Mem_Write_o  = (state == ACCESS) && wr && !err && reset;
        Mem_Read_o   = (state == ACCESS) && !wr && !err;
        Address_o    = (state == ACCESS) ? addr : '0;
        Write_Data_o = (state == ACCESS) ? wdata : '0;
        rsp_rdata_o  = rsp_rdata;
        rsp_err_o    = rsp_err;
    end

endmodule

// File: tb/tb_data_memory_arbiter.sv
// tb_data_memory_arbiter: directed and random cycles checked against a transaction-level model.
module tb_data_memory_arbiter;

    localparam logic [31:0] BASE = 32'h1001_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [1:0]  req_valid_i = '0, req_write_i = '0;
    logic [63:0] req_addr_i = '0, req_wdata_i = '0;
    logic [1:0]  req_ready_o, rsp_valid_o;
    logic [31:0] rsp_rdata_o, Address_o, Write_Data_o, Read_Data_i;
    logic        rsp_err_o, Mem_Write_o, Mem_Read_o;

    data_memory_arbiter dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid_i  (req_valid_i),
        .req_write_i  (req_write_i),
        .req_addr_i   (req_addr_i),
        .req_wdata_i  (req_wdata_i),
        .req_ready_o  (req_ready_o),
        .rsp_valid_o  (rsp_valid_o),
        .rsp_rdata_o  (rsp_rdata_o),
        .rsp_err_o    (rsp_err_o),
        .Mem_Write_o  (Mem_Write_o),
        .Mem_Read_o   (Mem_Read_o),
        .Address_o    (Address_o),
        .Write_Data_o (Write_Data_o),
        .Read_Data_i  (Read_Data_i)
    );

    always #5 clk = ~clk;

    // attached Data_Memory: combinational read, write on the edge
    logic [31:0] mem [256];
    logic        mem_ready = 1'b0;
    logic [31:0] mem_off;
    assign mem_off     = Address_o - BASE;
    assign Read_Data_i = mem[mem_off[9:2]];

    always @(posedge clk) begin
        if (!mem_ready) begin
            for (int i = 0; i < 256; i++) mem[i] <= 32'hA500_0000 | i;
            mem_ready <= 1'b1;
        end else if (Mem_Write_o) begin
            mem[mem_off[9:2]] <= Write_Data_o;
        end
    end

    int n_cmp = 0, n_bad = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // model: phase counts cycles since acceptance (0 = free)
    logic [31:0] ref_mem [256];
    int          phase = 0;
    logic        lg = 1'b1, m_owner = 1'b0, m_wr = 1'b0, m_err = 1'b0, rst_hold = 1'b1;
    logic [31:0] m_addr = '0, m_wdata = '0, m_rdata = '0;

    function automatic logic bad_addr(input logic [31:0] a);
        longint x = longint'(a);
        return (x % 4 != 0) || (x < longint'(BASE)) || (x >= longint'(BASE) + 4 * 256);
    endfunction

    task automatic cyc(input logic r, input logic [1:0] v, input logic [1:0] w,
                       input logic [63:0] a, input logic [63:0] d);
        logic        win;
        logic [1:0]  e_ready, e_rv;
        logic [31:0] ai, off;
        reset = r; req_valid_i = v; req_write_i = w; req_addr_i = a; req_wdata_i = d;
        #1;
        win     = (v == 2'b11) ? !lg : v[1];
        e_ready = (r && phase == 0 && v != 2'b00) ? (win ? 2'b10 : 2'b01) : 2'b00;
        e_rv    = (r && phase == 2) ? (m_owner ? 2'b10 : 2'b01) : 2'b00;
        chk("ready", req_ready_o, e_ready);
        chk("rsp_valid", rsp_valid_o, e_rv);
        chk("mem_write", Mem_Write_o, r && phase == 1 && m_wr && !m_err);
        chk("mem_read", Mem_Read_o, phase == 1 && !m_wr && !m_err);
        chk("address", Address_o, phase == 1 ? m_addr : 32'h0);
        chk("write_data", Write_Data_o, phase == 1 ? m_wdata : 32'h0);
        if (e_rv != 2'b00 || rst_hold) begin
            chk("rdata", rsp_rdata_o, rst_hold ? 32'h0 : m_rdata);
            chk("err", rsp_err_o, rst_hold ? 1'b0 : m_err);
        end
        if (!r) begin
            phase = 0;
            lg    = 1'b1;
        end else if (phase == 0) begin
            if (v != 2'b00) begin
                lg      = win;
                m_owner = win;
                m_wr    = w[win];
                ai      = win ? a[63:32] : a[31:0];
                m_addr  = ai;
                m_wdata = win ? d[63:32] : d[31:0];
                m_err   = bad_addr(ai);
                phase   = 1;
            end
        end else if (phase == 1) begin
            off     = m_addr - BASE;
            m_rdata = (!m_wr && !m_err) ? ref_mem[off[9:2]] : 32'h0;
            if (m_wr && !m_err) ref_mem[off[9:2]] = m_wdata;
            phase = 2;
        end else begin
            phase = 0;
        end
        rst_hold = !r;
        @(posedge clk);
        #1;
    endtask

    task automatic txn(input logic rq, input logic w, input logic [31:0] a, input logic [31:0] d);
        cyc(1'b1, 2'b01 << rq, {1'b0, w} << rq, {a, a}, {d, d});
        cyc(1'b1, 2'b00, 2'b00, 64'h0, 64'h0);
        cyc(1'b1, 2'b00, 2'b00, 64'h0, 64'h0);
    endtask

    function automatic logic [31:0] rnd_addr();
        int k = $urandom_range(0, 7);
        return (k == 0) ? $urandom :
               (k == 1) ? BASE + $urandom_range(0, 1023) :
               (k == 2) ? BASE + 32'd1024 + 4 * $urandom_range(0, 3) :
                          BASE + 4 * $urandom_range(0, 255);
    endfunction

    initial begin
        for (int i = 0; i < 256; i++) ref_mem[i] = 32'hA500_0000 | i;
        @(posedge clk);
        #1;
        cyc(1'b0, 2'b11, 2'b00, {BASE + 32'h24, BASE + 32'h20}, 64'h0);
        cyc(1'b0, 2'b11, 2'b00, {BASE + 32'h24, BASE + 32'h20}, 64'h0);
        for (int i = 0; i < 12; i++) cyc(1'b1, 2'b11, 2'b00, {BASE + 32'h24, BASE + 32'h20}, 64'h0);
        cyc(1'b1, 2'b00, 2'b00, 64'h0, 64'h0);
        txn(1'b0, 1'b1, 32'h1001_0008, 32'hDEAD_BEEF);
        txn(1'b0, 1'b0, 32'h1001_0008, 32'h0);
        txn(1'b1, 1'b0, 32'h1001_0002, 32'h0);
        txn(1'b1, 1'b0, 32'h1001_0400, 32'h0);
        txn(1'b1, 1'b0, 32'h1000_FFFC, 32'h0);
        cyc(1'b1, 2'b01, 2'b01, {32'h0, 32'h1001_0010}, {32'h0, 32'h1234_5678});
        cyc(1'b0, 2'b00, 2'b00, 64'h0, 64'h0);
        cyc(1'b0, 2'b00, 2'b00, 64'h0, 64'h0);
        cyc(1'b1, 2'b00, 2'b00, 64'h0, 64'h0);
        txn(1'b0, 1'b0, 32'h1001_0010, 32'h0);
        txn(1'b1, 1'b0, 32'h1001_03FC, 32'h0);
        for (int i = 0; i < 800; i++)
            cyc($urandom_range(0, 39) != 0, 2'($urandom), 2'($urandom),
                {rnd_addr(), rnd_addr()}, {32'($urandom), 32'($urandom)});
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/data_memory_arbiter.md
# data_memory_arbiter

Two-port arbiter and access sequencer in front of the single-port `Data_Memory`. Requester 0 is the core load/store path; requester 1 is the debug/loader port. It accepts one request per transaction using a round-robin grant and drives the memory strobes for exactly one cycle. It range-checks addresses against the data segment and returns read data or an error to the granted requester with fixed latency.

## Interface
Parameters:
- `DATA_WIDTH`, 32, data and address width.
- `MEMORY_DEPTH`, 256, words in the attached memory.
- `BASE_ADDR`, 32'h10010000, byte address of memory word 0.

Ports:
- `clk` input 1: single clock; all state updates on the rising edge.
- `reset` input 1: synchronous, active-low; sampled on the `clk` rising edge.
- `req_valid_i` input [1:0]: request pending, one bit per requester.
- `req_write_i` input [1:0]: 1 = store, 0 = load.
- `req_addr_i` input [2*DATA_WIDTH-1:0]: byte addresses; requester n uses slice n.
- `req_wdata_i` input [2*DATA_WIDTH-1:0]: store data, packed the same way.
- `req_ready_o` output [1:0]: acceptance pulse, one-hot or zero.
- `rsp_valid_o` output [1:0]: response pulse to the owning requester.
- `rsp_rdata_o` output [DATA_WIDTH-1:0]: load data; 0 for stores and errors.
- `rsp_err_o` output 1: qualified by `rsp_valid_o`; 1 = misaligned or out-of-range access.
- `Mem_Write_o` output 1: write strobe to `Data_Memory`.
- `Mem_Read_o` output 1: read enable to `Data_Memory`.
- `Address_o` output [DATA_WIDTH-1:0]: byte address to `Data_Memory`.
- `Write_Data_o` output [DATA_WIDTH-1:0]: store data to `Data_Memory`.
- `Read_Data_i` input [DATA_WIDTH-1:0]: combinational read data from `Data_Memory`.

## Operation
- FSM has three states: IDLE, ACCESS and RESP. Encoding is binary 2'b00, 2'b01 and 2'b10; 2'b11 recovers to IDLE.
- **IDLE**
  - If any `req_valid_i` bit is set, the round-robin picker selects a winner and `req_ready_o[winner]` is asserted in that cycle (Mealy).
  - At the edge the block captures owner, write flag, address and wdata, computes `err`, and moves to ACCESS.
  - With no request pending it stays in IDLE.
- **Round-robin**
  - `last_grant` register resets to 1, so requester 0 wins the first tie.
  - On a tie, the requester not equal to `last_grant` wins.
  - A sole requester always wins.
  - `last_grant` updates only on acceptance.
- **Error check**: `err` = (addr[1:0] != 0) OR (addr < BASE_ADDR) OR (addr >= BASE_ADDR + 4*MEMORY_DEPTH). Compare in 33-bit arithmetic so that BASE_ADDR + 4*MEMORY_DEPTH cannot wrap.
- **ACCESS**
  - `Address_o` and `Write_Data_o` are driven from the captured registers.
  - `Mem_Write_o` = write & !err & reset.
  - `Mem_Read_o` = !write & !err.
  - At the edge the response register loads `Read_Data_i` for a good load, otherwise 0; `rsp_err` loads `err`. State moves to RESP.
- **RESP**: `rsp_valid_o[owner]` = 1 and the response outputs are stable; state moves to IDLE. No new request is accepted in RESP.
- **Outside ACCESS**: `Mem_Write_o`, `Mem_Read_o`, `Address_o` and `Write_Data_o` are all 0.
- **Requester rules**: hold valid, address and data stable until ready is seen. Deasserting valid before ready is legal; the request is simply not taken.

## Timing
- **Reset values**: state IDLE, `last_grant` 1, and all outputs 0 (`req_ready_o`, `rsp_valid_o`, `rsp_rdata_o`, `rsp_err_o`, memory outputs).
- **Latency**:
  - Ready is in cycle T, the memory strobe in T+1 (the store commits at the end of T+1), and `rsp_valid_o` in T+2.
  - Throughput is one transaction per 3 cycles; back-to-back acceptance falls at T and T+3.
- **Simultaneous requests**: the loser keeps valid high and is served next, at T+3, irrespective of whether the winner re-requests.
- **Reset mid-operation**
  - Reset low in ACCESS suppresses `Mem_Write_o` in that cycle, so the store does not commit.
  - Reset low in any state returns the block to IDLE with no response pulse.
- **Errors**: an erroneous access never strobes memory but keeps the same 3-cycle timing.

## Structure
- Package `data_memory_pkg` holds `BASE_ADDR`, the state encoding constants, and the `err` range function.
- Sub-module `rr_arbiter_2` is purely combinational: inputs valid[1:0] and last_grant; outputs one-hot grant[1:0]. The `last_grant` register lives in the parent.

## Test plan
- **Reset**: reset=0 for 2 cycles with `req_valid_i`=2'b11 -> all outputs 0; the first grant after release goes to requester 0.
- **Store then load**: req0 stores 32'hDEADBEEF @32'h10010008, then loads the same address -> `Mem_Write_o` pulses once with `Address_o`=32'h10010008; load response `rsp_rdata_o`=32'hDEADBEEF, `rsp_err_o`=0, `rsp_valid_o`=2'b01 exactly 2 cycles after ready.
- **Contention**: both requesters hold valid continuously -> grants alternate 0,1,0,1 at cycles T, T+3, T+6, T+9.
- **Errors**: req1 loads 32'h10010002 (misaligned), then 32'h10010400 (one past the end), then 32'h1000FFFC (below base) -> `rsp_err_o`=1 and rdata 0 each time; `Mem_Read_o` and `Mem_Write_o` are never asserted.
- **Reset during ACCESS**: drop reset in the ACCESS cycle of a store of 32'h12345678 @32'h10010010 -> no write strobe, no response; a later load @32'h10010010 returns the prior contents.
- **Boundary**: load at the last word, 32'h100103FC -> `err`=0, memory read strobed, data returned.
